period_sig_gen: RTL and testbench

- Programmable periodic test-signal generator; the transmit-side counterpart of the measure unit's period-measurement/strobe generator.
- Drives a square wave of configured period and high time into the measure path for calibration and self-test.
- Configuration arrives over a valid/ready handshake. New settings are applied only at period boundaries, so the measure unit never sees a truncated or glitched period.

---
 rtl/period_sig_gen_pkg.sv | 16 +
 rtl/period_sig_gen_if.sv | 29 ++
 rtl/sig_gen_cfg_buf.sv | 81 ++++++++
 rtl/period_sig_gen.sv | 140 ++++++++++++++
 tb/tb_period_sig_gen.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/period_sig_gen_pkg.sv
// Shared measure-unit definitions for the periodic test-signal generator.
// Holds the default counter width, the smallest legal period and the
// one-hot generator state encoding.
package period_sig_gen_pkg;

  localparam int unsigned T_CNT_WIDTH = 32;
  localparam int unsigned MIN_PERIOD  = 2;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    LOAD = 4'b0010,
    HIGH = 4'b0100,
    LOW  = 4'b1000
  } period_sig_gen_state;

endpackage

// File: rtl/period_sig_gen_if.sv
// Configuration handshake bundle for period_sig_gen.
//   cfg_valid_i  : config offer (master -> slave)
//   cfg_ready_o  : config slot free (slave -> master)
//   cfg_period_i : period in clock cycles
//   cfg_high_i   : high time in clock cycles
interface period_sig_gen_if #(
  parameter int unsigned W = period_sig_gen_pkg::T_CNT_WIDTH
) ();

  logic         cfg_valid_i;
  logic         cfg_ready_o;
  logic [W-1:0] cfg_period_i;
  logic [W-1:0] cfg_high_i;

  modport master (
    output cfg_valid_i,
    output cfg_period_i,
    output cfg_high_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_period_i,
    input  cfg_high_i,
    output cfg_ready_o
  );

endinterface

// File: rtl/sig_gen_cfg_buf.sv
// Single-entry pending configuration buffer with legality check.
//   clk_i, arst_i      : clock, async active-low reset
//   cfg_valid_i        : config offer
//   cfg_period_i/high_i: offered config
//   consume_i          : generator has copied the pending entry
//   cfg_ready_o        : slot free (inverse of pending_valid_o)
//   pending_valid_o    : a legal config is waiting
//   pending_period_o   : pending period
//   pending_high_o     : pending high time
//   err_o              : sticky, last offered config was illegal
module sig_gen_cfg_buf #(
  parameter int unsigned T_CNT_WIDTH = period_sig_gen_pkg::T_CNT_WIDTH,
  parameter int unsigned MIN_PERIOD  = period_sig_gen_pkg::MIN_PERIOD
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   cfg_valid_i,
  input  logic [T_CNT_WIDTH-1:0] cfg_period_i,
  input  logic [T_CNT_WIDTH-1:0] cfg_high_i,
  input  logic                   consume_i,
  output logic                   cfg_ready_o,
  output logic                   pending_valid_o,
  output logic [T_CNT_WIDTH-1:0] pending_period_o,
  output logic [T_CNT_WIDTH-1:0] pending_high_o,
  output logic                   err_o
);

  logic                   pend_valid_q, pend_valid_d;
  logic [T_CNT_WIDTH-1:0] pend_period_q, pend_period_d;
  logic [T_CNT_WIDTH-1:0] pend_high_q, pend_high_d;
  logic                   err_q, err_d;
  logic                   accept_c;
  logic                   legal_c;

  // high < period together with period >= MIN_PERIOD bounds high to period-1
  assign legal_c  = (cfg_period_i >= T_CNT_WIDTH'(MIN_PERIOD)) &&
                    (cfg_high_i != '0) && (cfg_high_i < cfg_period_i);
  assign accept_c = cfg_valid_i && !pend_valid_q;

  // Slot update: illegal offers are consumed and only flag the error
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    err_d         = err_q;
    if (consume_i) begin
      pend_valid_d = 1'b0;
    end
    if (accept_c) begin
      if (legal_c) begin
        pend_valid_d  = 1'b1;
        pend_period_d = cfg_period_i;
        pend_high_d   = cfg_high_i;
        err_d         = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      pend_valid_q  <= 1'b0;
      pend_period_q <= '0;
      pend_high_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      err_q         <= err_d;
    end
  end

  assign cfg_ready_o      = !pend_valid_q;
  assign pending_valid_o  = pend_valid_q;
  assign pending_period_o = pend_period_q;
  assign pending_high_o   = pend_high_q;
  assign err_o            = err_q;

endmodule

// File: rtl/period_sig_gen.sv
// Programmable periodic test-signal generator. New configs are taken only
// at period boundaries so downstream never sees a truncated period.
//   clk_i, arst_i  : clock, async active-low reset
//   en_i           : run enable (level)
//   cfg            : config handshake (slave side)
//   sig_o          : generated square wave
//   period_start_o : pulse on the first high cycle of each period
//   active_o       : generator in HIGH or LOW
//   err_o          : sticky, last offered config illegal
//   period_cnt_o   : completed-period count, wraps
module period_sig_gen #(
  parameter int unsigned T_CNT_WIDTH = period_sig_gen_pkg::T_CNT_WIDTH,
  parameter int unsigned MIN_PERIOD  = period_sig_gen_pkg::MIN_PERIOD
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   en_i,
  period_sig_gen_if.slave        cfg,
  output logic                   sig_o,
  output logic                   period_start_o,
  output logic                   active_o,
  output logic                   err_o,
  output logic [T_CNT_WIDTH-1:0] period_cnt_o
);

  import period_sig_gen_pkg::*;

  period_sig_gen_state    state_q, state_d;
  logic [T_CNT_WIDTH-1:0] phase_cnt_q, phase_cnt_d;
  logic [T_CNT_WIDTH-1:0] act_period_q, act_period_d;
  logic [T_CNT_WIDTH-1:0] act_high_q, act_high_d;
  logic [T_CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic                   sig_q, sig_d;
  logic                   start_q, start_d;
  logic                   active_q, active_d;

  logic                   consume_c;
  logic                   ready_c;
  logic                   pend_valid;
  logic [T_CNT_WIDTH-1:0] pend_period;
  logic [T_CNT_WIDTH-1:0] pend_high;

  sig_gen_cfg_buf #(
    .T_CNT_WIDTH (T_CNT_WIDTH),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_cfg_buf (
    .clk_i            (clk_i),
    .arst_i           (arst_i),
    .cfg_valid_i      (cfg.cfg_valid_i),
    .cfg_period_i     (cfg.cfg_period_i),
    .cfg_high_i       (cfg.cfg_high_i),
    .consume_i        (consume_c),
    .cfg_ready_o      (ready_c),
    .pending_valid_o  (pend_valid),
    .pending_period_o (pend_period),
    .pending_high_o   (pend_high),
    .err_o            (err_o)
  );

  assign cfg.cfg_ready_o = ready_c;

  // Next state; outputs are registered from the next state so sig_o
  // tracks the HIGH state without a cycle of skew
  always_comb begin
    state_d      = state_q;
    phase_cnt_d  = phase_cnt_q;
    act_period_d = act_period_q;
    act_high_d   = act_high_q;
    period_cnt_d = period_cnt_q;
    consume_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_valid && en_i) state_d = LOAD;
      end
      LOAD: begin
        act_period_d = pend_period;
        act_high_d   = pend_high;
        phase_cnt_d  = pend_high - T_CNT_WIDTH'(1);
        consume_c    = 1'b1;
        state_d      = HIGH;
      end
      HIGH: begin
        if (phase_cnt_q == '0) begin
          phase_cnt_d = act_period_q - act_high_q - T_CNT_WIDTH'(1);
          state_d     = LOW;
        end else begin
          phase_cnt_d = phase_cnt_q - T_CNT_WIDTH'(1);
        end
      end
      LOW: begin
        if (phase_cnt_q == '0) begin
          period_cnt_d = period_cnt_q + T_CNT_WIDTH'(1);
          if (!en_i) begin
            state_d = IDLE;
          end else if (pend_valid) begin
            // extra LOAD cycle stretches this boundary period by one
            state_d = LOAD;
          end else begin
            phase_cnt_d = act_high_q - T_CNT_WIDTH'(1);
            state_d     = HIGH;
          end
        end else begin
          phase_cnt_d = phase_cnt_q - T_CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    sig_d    = (state_d == HIGH);
    start_d  = (state_d == HIGH) && (state_q != HIGH);
    active_d = (state_d == HIGH) || (state_d == LOW);
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q      <= IDLE;
      phase_cnt_q  <= '0;
      act_period_q <= '0;
      act_high_q   <= '0;
      period_cnt_q <= '0;
      sig_q        <= 1'b0;
      start_q      <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      act_period_q <= act_period_d;
      act_high_q   <= act_high_d;
      period_cnt_q <= period_cnt_d;
      sig_q        <= sig_d;
      start_q      <= start_d;
      active_q     <= active_d;
    end
  end

  assign sig_o          = sig_q;
  assign period_start_o = start_q;
  assign active_o       = active_q;
  assign period_cnt_o   = period_cnt_q;

endmodule

// File: tb/tb_period_sig_gen.sv
// Self-checking bench for period_sig_gen: expected per-cycle output
// vectors are queued when a config is offered and popped on each falling
// edge while the generator runs.
module tb_period_sig_gen;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic         rdy;
    logic         sig;
    logic         st;
    logic         act;
    logic [W-1:0] cnt;
  } exp_t;

  logic         clk_i;
  logic         arst_i;
  logic         en_i;
  logic         sig_o;
  logic         period_start_o;
  logic         active_o;
  logic         err_o;
  logic [W-1:0] period_cnt_o;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  period_sig_gen_if #(.W(W)) cfg_if ();

  period_sig_gen #(.T_CNT_WIDTH(W), .MIN_PERIOD(2)) dut (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .en_i           (en_i),
    .cfg            (cfg_if),
    .sig_o          (sig_o),
    .period_start_o (period_start_o),
    .active_o       (active_o),
    .err_o          (err_o),
    .period_cnt_o   (period_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic exp_t obs();
    return {cfg_if.cfg_ready_o, sig_o, period_start_o, active_o, period_cnt_o};
  endfunction

  task automatic push_one(input logic r, input logic s, input logic t,
                          input logic a, input int c);
    exp_t e;
    e.rdy = r; e.sig = s; e.st = t; e.act = a; e.cnt = W'(c);
    sb.push_back(e);
  endtask

  // Free-running periods after the generator is in HIGH/LOW
  task automatic push_periods(input int p, input int h, input int n, input int c0);
    for (int i = 0; i < p * n; i++)
      push_one(1'b1, (i % p) < h, (i % p) == 0, 1'b1, c0 + i / p);
  endtask

  task automatic do_reset();
    arst_i = 1'b0;
    en_i = 1'b1;
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_period_i = '0;
    cfg_if.cfg_high_i = '0;
    repeat (2) @(negedge clk_i);
    arst_i = 1'b1;
    @(negedge clk_i);
  endtask

  // One-cycle offer; returns on the falling edge after the accept edge
  task automatic offer(input int p, input int h);
    cfg_if.cfg_valid_i = 1'b1;
    cfg_if.cfg_period_i = W'(p);
    cfg_if.cfg_high_i = W'(h);
    @(negedge clk_i);
    cfg_if.cfg_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    exp_t rv;
    rv = {1'b1, 1'b0, 1'b0, 1'b0, W'(0)};
    do_reset();
    arst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (obs() !== rv || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held got %h err %b exp %h err 0", obs(), err_o, rv);
    end
    arst_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (obs() !== rv || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_released got %h err %b exp %h err 0", obs(), err_o, rv);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int j;
    do_reset();
    offer(10, 3);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_periods(10, 3, 3, 0);
    j = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL basic j=%0d got %h exp %h", j, obs(), e);
      end
      @(negedge clk_i);
      j++;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    int j;
    int bad_h[2] = '{0, 12};
    do_reset();
    foreach (bad_h[k]) begin
      n_cmp++;
      if (cfg_if.cfg_ready_o !== 1'b1) begin
        n_bad++;
        $display("FAIL illegal_ready_pre h=%0d got %b exp 1", bad_h[k], cfg_if.cfg_ready_o);
      end
      offer(10, bad_h[k]);
      n_cmp++;
      if ({err_o, cfg_if.cfg_ready_o, sig_o, active_o} !== 4'b1100) begin
        n_bad++;
        $display("FAIL illegal_flag h=%0d got err/rdy/sig/act %b%b%b%b exp 1100",
                 bad_h[k], err_o, cfg_if.cfg_ready_o, sig_o, active_o);
      end
    end
    offer(10, 5);
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_clear got err %b exp 0", err_o);
    end
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_periods(10, 5, 2, 0);
    j = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL legal_after_err j=%0d got %h exp %h", j, obs(), e);
      end
      @(negedge clk_i);
      j++;
    end
  endtask

  task automatic test_reconfig();
    exp_t e;
    int j;
    do_reset();
    offer(10, 3);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_periods(10, 3, 1, 0);
    // second period: new config offered in its 2nd high cycle
    for (int i = 0; i < 10; i++)
      push_one(i < 2, i < 3, i == 0, 1'b1, 1);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 2);
    push_periods(6, 2, 2, 2);
    j = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL reconfig j=%0d got %h exp %h", j, obs(), e);
      end
      if (j == 13) begin
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_period_i = W'(6);
        cfg_if.cfg_high_i = W'(2);
      end
      if (j == 15) cfg_if.cfg_valid_i = 1'b0;
      @(negedge clk_i);
      j++;
    end
  endtask

  task automatic test_min_period();
    exp_t e;
    int j;
    do_reset();
    offer(2, 1);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_periods(2, 1, 4, 0);
    j = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL min_period j=%0d got %h exp %h", j, obs(), e);
      end
      @(negedge clk_i);
      j++;
    end
  endtask

  task automatic test_en_drop();
    exp_t e;
    int j;
    do_reset();
    offer(10, 3);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_periods(10, 3, 1, 0);
    for (int i = 0; i < 4; i++)
      push_one(1'b1, 1'b0, 1'b0, 1'b0, 1);
    j = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL en_drop j=%0d got %h exp %h", j, obs(), e);
      end
      if (j == 3) en_i = 1'b0;
      @(negedge clk_i);
      j++;
    end
    en_i = 1'b1;
  endtask

  task automatic test_async_reset();
    exp_t e;
    exp_t rv;
    int j;
    rv = {1'b1, 1'b0, 1'b0, 1'b0, W'(0)};
    do_reset();
    offer(10, 3);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_one(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_periods(10, 3, 1, 0);
    push_one(1'b1, 1'b1, 1'b1, 1'b1, 1);
    push_one(1'b0, 1'b1, 1'b0, 1'b1, 1);
    j = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL pre_reset j=%0d got %h exp %h", j, obs(), e);
      end
      if (j == 12) begin
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_period_i = W'(6);
        cfg_if.cfg_high_i = W'(2);
      end
      @(negedge clk_i);
      j++;
    end
    n_cmp++;
    if (sig_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_high got sig %b exp 1", sig_o);
    end
    cfg_if.cfg_valid_i = 1'b0;
    arst_i = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== rv || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got %h err %b exp %h err 0", obs(), err_o, rv);
    end
    @(negedge clk_i);
    arst_i = 1'b1;
    // pending config was lost, so the generator must stay idle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (obs() !== rv) begin
        n_bad++;
        $display("FAIL post_reset_idle i=%0d got %h exp %h", i, obs(), rv);
      end
    end
  endtask

  initial begin
    arst_i = 1'b0;
    en_i = 1'b1;
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_period_i = '0;
    cfg_if.cfg_high_i = '0;
    test_reset();
    test_basic();
    test_illegal();
    test_reconfig();
    test_min_period();
    test_en_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
